// File: rtl/c_barramento_fifo.sv
// Barramento bus receiver with an internal FIFO. Words are accepted from the source
// over the data_valid/data_read handshake and are drained by a local consumer via rd_en.
`timescale 1ns / 1ps

module c_barramento_fifo #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ACK_LEN = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_valid,
    input  logic [WIDTH-1:0]         data,
    output logic                     data_read,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0]  AckLast = 4'(ACK_LEN - 1);
    localparam logic [AW:0] LevelFull = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StWaitRelease
    } state_e;

    state_e                 state_q;
    logic [3:0]             ack_cnt_q;
    logic                   data_read_q;

    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [AW:0]            level_q, level_d;
    logic [WIDTH-1:0]       rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    logic                   wr_fire;
    logic                   rd_fire;

    assign empty = (level_q == '0);
    assign full  = (level_q == LevelFull);

    // Write only when idle and space is known from the registered level; a read on the
    // same edge does not free the slot until the next edge.
    assign wr_fire = (state_q == StIdle) && data_valid && !full;
    assign rd_fire = rd_en && !empty;

    // Receive handshake FSM: one write per data_valid assertion, data_read held ACK_LEN cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ack_cnt_q   <= '0;
            data_read_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (wr_fire) begin
                        state_q     <= StAck;
                        ack_cnt_q   <= AckLast;
                        data_read_q <= 1'b1;
                    end
                end
                StAck: begin
                    if (ack_cnt_q == '0) begin
                        data_read_q <= 1'b0;
                        state_q     <= data_valid ? StWaitRelease : StIdle;
                    end else begin
                        ack_cnt_q <= ack_cnt_q - 4'd1;
                    end
                end
                StWaitRelease: begin
                    if (!data_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    data_read_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wptr_q] <= data;
        end
    end

    // Pointer, occupancy and read-port next state; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (wr_fire) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_fire) begin
            rptr_d     = rptr_q + 1'b1;
            rd_data_d  = mem_q[rptr_q];
            rd_valid_d = 1'b1;
        end
        unique case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO bookkeeping and registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign data_read = data_read_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign level     = level_q;

endmodule

// File: tb/tb_c_barramento_fifo.sv
// Bench for c_barramento_fifo: two builds (8-bit/ACK 1 and 16-bit/ACK 3), each checked
// every cycle against a queue-based model, plus directed literal expectations.
`timescale 1ns / 1ps

module tb_c_barramento_fifo;

    logic        clk;
    logic        reset;
    logic        dv   [2];
    logic [15:0] din  [2];
    logic        rde  [2];
    logic        dr   [2];
    logic        rdv  [2];
    logic        emp  [2];
    logic        ful  [2];
    logic [15:0] rdd  [2];
    logic [3:0]  lvl  [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int unsigned W  = (g == 0) ? 8 : 16;
        localparam int unsigned AL = (g == 0) ? 1 : 3;

        logic [W-1:0] rd_data_w;
        logic [2:0]   level_w;
        logic         dr_w, rdv_w, emp_w, ful_w;

        c_barramento_fifo #(
            .WIDTH   (W),
            .DEPTH   (4),
            .ACK_LEN (AL)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .data_valid (dv[g]),
            .data       (din[g][W-1:0]),
            .data_read  (dr_w),
            .rd_en      (rde[g]),
            .rd_data    (rd_data_w),
            .rd_valid   (rdv_w),
            .empty      (emp_w),
            .full       (ful_w),
            .level      (level_w)
        );

        assign dr[g]  = dr_w;
        assign rdv[g] = rdv_w;
        assign emp[g] = emp_w;
        assign ful[g] = ful_w;
        assign rdd[g] = 16'(rd_data_w);
        assign lvl[g] = 4'(level_w);

        // Model: a queue of stored words, cycles of acknowledge left, and a
        // "source still holding valid" flag.
        logic [W-1:0] mq [$];
        int           ack_left;
        bit           waiting;
        logic [W-1:0] m_rdd;
        bit           m_rdv;
        bit           was_full, was_empty;

        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                mq.delete();
                ack_left = 0;
                waiting  = 1'b0;
                m_rdd    = '0;
                m_rdv    = 1'b0;
            end else begin
                was_full  = (mq.size() == 4);
                was_empty = (mq.size() == 0);
                m_rdv = 1'b0;
                if (rde[g] && !was_empty) begin
                    m_rdd = mq.pop_front();
                    m_rdv = 1'b1;
                end
                if (ack_left > 0) begin
                    ack_left--;
                    if (ack_left == 0 && dv[g]) waiting = 1'b1;
                end else if (waiting) begin
                    if (!dv[g]) waiting = 1'b0;
                end else if (dv[g] && !was_full) begin
                    mq.push_back(din[g][W-1:0]);
                    ack_left = AL;
                end
            end
        end

        always @(negedge clk) begin
            check($sformatf("c%0d data_read", g), 32'(dr[g]),  32'(ack_left > 0));
            check($sformatf("c%0d rd_valid", g),  32'(rdv[g]), 32'(m_rdv));
            check($sformatf("c%0d rd_data", g),   32'(rdd[g]), 32'(m_rdd));
            check($sformatf("c%0d level", g),     32'(lvl[g]), 32'(mq.size()));
            check($sformatf("c%0d empty", g),     32'(emp[g]), 32'(mq.size() == 0));
            check($sformatf("c%0d full", g),      32'(ful[g]), 32'(mq.size() == 4));
        end
    end

    // Present one word, wait for the acknowledge, count its high cycles, then release.
    task automatic send(input int c, input logic [15:0] d, output int hi);
        @(negedge clk);
        dv[c]  = 1'b1;
        din[c] = d;
        hi     = 0;
        for (int i = 0; i < 20 && !dr[c]; i++) @(negedge clk);
        if (!dr[c]) check($sformatf("c%0d ack timeout", c), 32'(dr[c]), 32'd1);
        while (dr[c] && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        dv[c] = 1'b0;
    endtask

    task automatic pop(input int c);
        @(negedge clk);
        rde[c] = 1'b1;
        @(negedge clk);
        rde[c] = 1'b0;
    endtask

    int hi;

    initial begin
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            dv[c]  = 1'b0;
            din[c] = '0;
            rde[c] = 1'b0;
        end

        // Reset state
        #12;
        check("lit reset data_read", 32'(dr[0]),  32'd0);
        check("lit reset rd_valid",  32'(rdv[0]), 32'd0);
        check("lit reset rd_data",   32'(rdd[0]), 32'd0);
        check("lit reset empty",     32'(emp[0]), 32'd1);
        check("lit reset full",      32'(ful[0]), 32'd0);
        check("lit reset level",     32'(lvl[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("lit idle level", 32'(lvl[0]), 32'd0);
        check("lit idle data_read", 32'(dr[0]), 32'd0);

        // Single word
        send(0, 16'h15, hi);
        check("lit single ack cycles", 32'(hi), 32'd1);
        check("lit single level", 32'(lvl[0]), 32'd1);
        pop(0);
        check("lit single rd_data", 32'(rdd[0]), 32'h15);
        check("lit single rd_valid", 32'(rdv[0]), 32'd1);
        check("lit single empty", 32'(emp[0]), 32'd1);

        // Fill, stall, pop-unblocks, drain across pointer wrap
        for (int i = 0; i < 4; i++) begin
            send(0, 16'(8'hA1 + i), hi);
            check("lit fill ack cycles", 32'(hi), 32'd1);
        end
        check("lit fill full", 32'(ful[0]), 32'd1);
        check("lit fill level", 32'(lvl[0]), 32'd4);
        @(negedge clk);
        dv[0]  = 1'b1;
        din[0] = 16'hA5;
        repeat (3) begin
            @(negedge clk);
            check("lit stall data_read", 32'(dr[0]), 32'd0);
        end
        rde[0] = 1'b1;
        @(negedge clk);
        rde[0] = 1'b0;
        check("lit stall pop rd_data", 32'(rdd[0]), 32'hA1);
        check("lit stall blocked edge", 32'(dr[0]), 32'd0);
        check("lit stall level after pop", 32'(lvl[0]), 32'd3);
        @(negedge clk);
        check("lit stall captured", 32'(dr[0]), 32'd1);
        check("lit stall level refill", 32'(lvl[0]), 32'd4);
        for (int i = 0; i < 20 && dr[0]; i++) @(negedge clk);
        dv[0]  = 1'b0;
        rde[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lit drain order", 32'(rdd[0]), 32'(8'hA2 + i));
            check("lit drain rd_valid", 32'(rdv[0]), 32'd1);
        end
        rde[0] = 1'b0;
        @(negedge clk);
        check("lit drain empty", 32'(emp[0]), 32'd1);
        check("lit drain rd_valid low", 32'(rdv[0]), 32'd0);

        // Held valid: exactly one write
        dv[0]  = 1'b1;
        din[0] = 16'h3C;
        hi     = 0;
        repeat (6) begin
            @(negedge clk);
            if (dr[0]) hi++;
        end
        check("lit held ack cycles", 32'(hi), 32'd1);
        check("lit held level", 32'(lvl[0]), 32'd1);
        dv[0] = 1'b0;
        pop(0);
        check("lit held rd_data", 32'(rdd[0]), 32'h3C);
        check("lit held empty", 32'(emp[0]), 32'd1);

        // Wide build with three-cycle acknowledge
        send(1, 16'hBEEF, hi);
        check("lit wide ack cycles", 32'(hi), 32'd3);
        pop(1);
        check("lit wide rd_data", 32'(rdd[1]), 32'hBEEF);
        check("lit wide rd_valid", 32'(rdv[1]), 32'd1);
        pop(1);
        check("lit wide empty read rd_valid", 32'(rdv[1]), 32'd0);
        check("lit wide empty read rd_data", 32'(rdd[1]), 32'hBEEF);

        // Reset in the middle of an acknowledge
        send(0, 16'h11, hi);
        @(negedge clk);
        dv[0]  = 1'b1;
        din[0] = 16'h22;
        @(negedge clk);
        check("lit midrst pre data_read", 32'(dr[0]), 32'd1);
        check("lit midrst pre level", 32'(lvl[0]), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("lit midrst data_read", 32'(dr[0]), 32'd0);
        check("lit midrst level", 32'(lvl[0]), 32'd0);
        check("lit midrst empty", 32'(emp[0]), 32'd1);
        @(negedge clk);
        dv[0] = 1'b0;
        reset = 1'b1;
        send(0, 16'h15, hi);
        check("lit post-reset ack cycles", 32'(hi), 32'd1);
        check("lit post-reset level", 32'(lvl[0]), 32'd1);
        pop(0);
        check("lit post-reset rd_data", 32'(rdd[0]), 32'h15);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
